// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared core widths, NOP encoding and fetch state encoding.
package instruction_fetch_pkg;
  localparam int W = 16;
  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [W-1:0] NOP_INSTR = {NOP, 12'h000};
  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: fetch-stage control, instruction memory and IF/ID signals.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;
  logic         stall_id;
  logic         redirect_ex;
  logic [W-1:0] redirect_target_ex;
  logic         imem_req_if;
  logic [W-1:0] imem_addr_if;
  logic         imem_ack_mem;
  logic [W-1:0] imem_data_mem;
  logic [W-1:0] instruction_if;
  logic [W-1:0] next_program_counter_if;
  logic         valid_if;
  modport master (
    input  stall_id, redirect_ex, redirect_target_ex, imem_ack_mem, imem_data_mem,
    output imem_req_if, imem_addr_if, instruction_if, next_program_counter_if, valid_if
  );
  modport slave (
    output stall_id, redirect_ex, redirect_target_ex, imem_ack_mem, imem_data_mem,
    input  imem_req_if, imem_addr_if, instruction_if, next_program_counter_if, valid_if
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, req/ack instruction-memory fetch, one-entry stall buffer and redirect flush.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [W-1:0] RESET_PC = 16'h0000
) (
  input logic clk,
  input logic reset,
  instruction_fetch_if.master io_fetch
);
  fetch_state_t r_state, w_state;
  logic [W-1:0] r_pc, w_pc, r_req_addr, w_req_addr;
  logic [W-1:0] r_hold_instr, w_hold_instr, r_hold_pc, w_hold_pc;
  logic [W-1:0] r_instr, w_instr, r_npc, w_npc;
  logic         r_valid, w_valid;
  logic [W-1:0] w_req_inc, w_hold_inc;
  logic         w_ack, w_stall, w_redir;
  logic [W-1:0] w_target;
  assign w_ack = io_fetch.imem_ack_mem;
  assign w_stall = io_fetch.stall_id;
  assign w_redir = io_fetch.redirect_ex;
  assign w_target = io_fetch.redirect_target_ex;
  assign w_req_inc = r_req_addr + 1'b1;
  assign w_hold_inc = r_hold_pc + 1'b1;
  assign io_fetch.imem_req_if = r_state != S_HOLD;
  assign io_fetch.imem_addr_if = r_req_addr;
  assign io_fetch.instruction_if = r_instr;
  assign io_fetch.next_program_counter_if = r_npc;
  assign io_fetch.valid_if = r_valid;
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_req_addr = r_req_addr;
    w_hold_instr = r_hold_instr;
    w_hold_pc = r_hold_pc;
    w_instr = r_instr;
    w_npc = r_npc;
    w_valid = r_valid;
    case (r_state)
      S_REQ:
        if (w_redir) begin
          w_pc = w_target;
          if (w_ack) w_req_addr = w_target;
          else w_state = S_DRAIN;
        end else if (w_ack && w_stall) begin
          w_hold_instr = io_fetch.imem_data_mem;
          w_hold_pc = r_req_addr;
          w_state = S_HOLD;
        end else if (w_ack) begin
          w_instr = io_fetch.imem_data_mem;
          w_npc = w_req_inc;
          w_valid = 1'b1;
          w_pc = w_req_inc;
          w_req_addr = w_req_inc;
        end else if (!w_stall) begin
          w_instr = NOP_INSTR;
          w_npc = '0;
          w_valid = 1'b0;
        end
      S_HOLD:
        if (w_redir) begin
          w_hold_instr = NOP_INSTR;
          w_hold_pc = '0;
          w_pc = w_target;
          w_req_addr = w_target;
          w_state = S_REQ;
        end else if (!w_stall) begin
          w_instr = r_hold_instr;
          w_npc = w_hold_inc;
          w_valid = 1'b1;
          w_pc = w_hold_inc;
          w_req_addr = w_hold_inc;
          w_state = S_REQ;
        end
      S_DRAIN: begin
        // the in-flight request must complete before the new target is issued
        w_pc = w_redir ? w_target : r_pc;
        if (w_ack) begin
          w_req_addr = w_pc;
          w_state = S_REQ;
        end
      end
      default: w_state = S_REQ;
    endcase
    if (w_redir) begin
      w_instr = NOP_INSTR;
      w_npc = '0;
      w_valid = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_REQ;
      r_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc <= '0;
      r_instr <= NOP_INSTR;
      r_npc <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_req_addr <= w_req_addr;
      r_hold_instr <= w_hold_instr;
      r_hold_pc <= w_hold_pc;
      r_instr <= w_instr;
      r_npc <= w_npc;
      r_valid <= w_valid;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random-latency memory and stall/redirect traffic against a queue-based fetch model.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  instruction_fetch_if bus ();
  instruction_fetch dut (.clk(clk), .reset(reset), .io_fetch(bus.master));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] h;
    h = a * 16'h9E37;
    return a == 16'h0000 ? 16'h1234 : a == 16'h0001 ? 16'h5678 : h ^ 16'h5A5A;
  endfunction
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;
  ent_t hold_q[$];
  logic [15:0] m_fetch, m_target, m_instr, m_npc;
  logic m_valid;
  bit m_discard;
  bit pend;
  int cnt;
  int mem_lat = 0;
  logic [15:0] p_addr;
  task automatic model_reset();
    hold_q.delete();
    m_fetch = 16'h0000;
    m_target = 16'h0000;
    m_instr = 16'h0000;
    m_npc = 16'h0000;
    m_valid = 1'b0;
    m_discard = 1'b0;
    pend = 1'b0;
  endtask
  task automatic set_nop();
    m_instr = 16'h0000;
    m_npc = 16'h0000;
    m_valid = 1'b0;
  endtask
  task automatic step(input bit st, input bit rd, input logic [15:0] tg);
    bit ack;
    logic [15:0] d;
    ent_t e;
    @(negedge clk);
    check("req", 32'(bus.imem_req_if), 32'(hold_q.size() == 0));
    if (hold_q.size() == 0) check("addr", 32'(bus.imem_addr_if), 32'(m_fetch));
    check("instr", 32'(bus.instruction_if), 32'(m_instr));
    check("npc", 32'(bus.next_program_counter_if), 32'(m_npc));
    check("valid", 32'(bus.valid_if), 32'(m_valid));
    ack = 1'b0;
    d = 16'(the_junk());
    if (pend) begin
      check("hs_req", 32'(bus.imem_req_if), 32'd1);
      check("hs_addr", 32'(bus.imem_addr_if), 32'(p_addr));
    end
    if (bus.imem_req_if) begin
      if (!pend) begin
        pend = 1'b1;
        p_addr = bus.imem_addr_if;
        cnt = mem_lat < 0 ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (cnt == 0) begin
        ack = 1'b1;
        d = mem_word(p_addr);
        pend = 1'b0;
      end else cnt--;
    end
    bus.stall_id = st;
    bus.redirect_ex = rd;
    bus.redirect_target_ex = tg;
    bus.imem_ack_mem = ack;
    bus.imem_data_mem = d;
    if (hold_q.size() != 0) begin
      if (rd) begin
        hold_q.delete();
        m_fetch = tg;
        set_nop();
      end else if (!st) begin
        e = hold_q.pop_front();
        m_instr = e.instr;
        m_npc = e.pc + 16'd1;
        m_valid = 1'b1;
        m_fetch = e.pc + 16'd1;
      end
    end else if (m_discard) begin
      if (rd) begin
        m_target = tg;
        set_nop();
      end
      if (ack) begin
        m_discard = 1'b0;
        m_fetch = m_target;
      end
    end else if (rd) begin
      if (ack) m_fetch = tg;
      else begin
        m_discard = 1'b1;
        m_target = tg;
      end
      set_nop();
    end else if (ack && st) begin
      hold_q.push_back('{instr: d, pc: m_fetch});
    end else if (ack) begin
      m_instr = d;
      m_npc = m_fetch + 16'd1;
      m_valid = 1'b1;
      m_fetch = m_fetch + 16'd1;
    end else if (!st) set_nop();
  endtask
  function automatic logic [31:0] the_junk();
    return $urandom;
  endfunction
  task automatic peek();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.stall_id = 1'b0;
    bus.redirect_ex = 1'b0;
    bus.redirect_target_ex = 16'h0000;
    bus.imem_ack_mem = 1'b0;
    bus.imem_data_mem = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mem_lat = 0;
    step(0, 0, 16'h0);
    peek();
    check("tp_i0", 32'(bus.instruction_if), 32'h1234);
    check("tp_n0", 32'(bus.next_program_counter_if), 32'h0001);
    check("tp_v0", 32'(bus.valid_if), 32'd1);
    step(0, 0, 16'h0);
    peek();
    check("tp_i1", 32'(bus.instruction_if), 32'h5678);
    check("tp_n1", 32'(bus.next_program_counter_if), 32'h0002);
    for (int i = 0; i < 20 && m_fetch != 16'h0005; i++) step(0, 0, 16'h0);
    peek();
    check("tp_at5", 32'(bus.imem_addr_if), 32'h0005);
    mem_lat = 3;
    repeat (5) step(0, 0, 16'h0);
    mem_lat = 0;
    repeat (2) step(0, 0, 16'h0);
    step(0, 1, 16'h0003);
    step(1, 0, 16'h0);
    step(1, 0, 16'h0);
    peek();
    check("tp_hold_req", 32'(bus.imem_req_if), 32'd0);
    step(0, 0, 16'h0);
    peek();
    check("tp_rel_i", 32'(bus.instruction_if), 32'(mem_word(16'h0003)));
    check("tp_rel_n", 32'(bus.next_program_counter_if), 32'h0004);
    check("tp_rel_a", 32'(bus.imem_addr_if), 32'h0004);
    step(0, 1, 16'h0007);
    mem_lat = 3;
    step(0, 0, 16'h0);
    step(0, 1, 16'h0040);
    peek();
    check("tp_drain_a", 32'(bus.imem_addr_if), 32'h0007);
    check("tp_drain_v", 32'(bus.valid_if), 32'd0);
    repeat (5) step(0, 0, 16'h0);
    mem_lat = 0;
    repeat (3) step(0, 0, 16'h0);
    step(1, 0, 16'h0);
    step(1, 1, 16'h0100);
    peek();
    check("tp_hr_v", 32'(bus.valid_if), 32'd0);
    check("tp_hr_i", 32'(bus.instruction_if), 32'h0000);
    check("tp_hr_a", 32'(bus.imem_addr_if), 32'h0100);
    step(0, 1, 16'hFFFF);
    step(0, 0, 16'h0);
    peek();
    check("tp_wrap_n", 32'(bus.next_program_counter_if), 32'h0000);
    check("tp_wrap_a", 32'(bus.imem_addr_if), 32'h0000);
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] tg;
      tg = $urandom_range(0, 3) == 0 ? 16'hFFFF - 16'($urandom_range(0, 2)) : 16'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tg);
    end
    mem_lat = 0;
    repeat (6) step(0, 0, 16'h0);
    mem_lat = 3;
    step(0, 0, 16'h0);
    step(0, 1, 16'h0300);
    @(negedge clk);
    #2;
    bus.redirect_ex = 1'b0;
    bus.imem_ack_mem = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_i", 32'(bus.instruction_if), 32'h0000);
    check("rst_v", 32'(bus.valid_if), 32'd0);
    check("rst_n", 32'(bus.next_program_counter_if), 32'h0000);
    check("rst_a", 32'(bus.imem_addr_if), 32'h0000);
    check("rst_r", 32'(bus.imem_req_if), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_lat = 0;
    repeat (4) step(0, 0, 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the 16-bit pipelined core; the producer that feeds the instruction decode stage.
- Owns the program counter and issues word-addressed requests to instruction memory over a req/ack handshake.
- Presents one instruction per cycle to decode as `instruction_if` and `next_program_counter_if`.
- Handles decode stalls and execute-stage redirects, inserting NOPs (opcode 4'b0000) as bubbles.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `stall_id`  in  1  decode cannot accept; hold IF/ID outputs.
- `redirect_ex`  in  1  branch/jump resolved to a new PC; flush.
- `redirect_target_ex`  in  16  new PC when `redirect_ex`=1.
- `imem_req_if`  out  1  memory request.
- `imem_addr_if`  out  16  word address of request.
- `imem_ack_mem`  in  1  data valid on `imem_data_mem` this cycle.
- `imem_data_mem`  in  16  instruction word.
- `instruction_if`  out  16  instruction to decode; 16'h0000 (NOP) when invalid.
- `next_program_counter_if`  out  16  address of `instruction_if` + 1.
- `valid_if`  out  1  `instruction_if` is a real fetched instruction.

## Operation
- PC is a word address; increment is +1, wraps 16'hFFFF→16'h0000.
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: address of the outstanding request.
  - `hold_instr` / `hold_pc`: one-entry buffer.
  - IF/ID output registers.
- Priority per cycle: reset > redirect > stall > normal.
- States:
  - REQ: `imem_req_if`=1, `imem_addr_if`=`req_addr`.
    - On ack, no stall, no redirect: outputs ← {data, `req_addr`+1, valid 1}; `pc`,`req_addr` ← `req_addr`+1; stay REQ.
    - On ack with stall: data → hold buffer; go HOLD.
    - On ack with redirect: drop data; `pc`,`req_addr` ← target; stay REQ.
    - No ack, redirect: `pc` ← target; go DRAIN.
    - No ack, no redirect, no stall: outputs ← NOP, valid 0.
  - HOLD: `imem_req_if`=0.
    - When stall drops: outputs ← buffer; `req_addr` ← `hold_pc`+1; go REQ.
    - Redirect: clear buffer; `req_addr` ← target; go REQ.
  - DRAIN: `imem_req_if`=1 at the old `req_addr`, which stays stable until ack.
    - On ack: discard data; `req_addr` ← `pc`; go REQ.
    - A further redirect while in DRAIN overwrites `pc`.
- Handshake rule: once `imem_req_if` is raised, `imem_addr_if` and `imem_req_if` stay stable until `imem_ack_mem`. Redirect never withdraws a request.
- Redirect (any state) clears the output registers to NOP, valid 0, at the same edge, even if `stall_id`=1.
- Stall without redirect: output registers unchanged.

## Timing
- Reset values:
  - state REQ; `pc`=`req_addr`=`RESET_PC`.
  - `imem_req_if`=1 and `imem_addr_if`=`RESET_PC` immediately after reset deasserts.
  - `instruction_if`=16'h0000, `next_program_counter_if`=16'h0000, `valid_if`=0.
  - Hold buffer cleared.
- Memory: ack no earlier than the cycle after req; data sampled in the ack cycle.
- Latency: ack in cycle N → instruction on outputs from cycle N+1. With single-cycle memory, sustained throughput is 1 instruction/cycle.
- Redirect in cycle N → outputs NOP at N+1; first target fetch issued at N+1 (from REQ/HOLD) or after the drain ack.
- Reset mid-request: the request is abandoned. Memory shares the same `reset`.

## Structure
- Shared core package holds:
  - `NOP` opcode 4'b0000 and `NOP_INSTR` 16'h0000, shared with decode.
  - Fetch state encoding REQ/HOLD/DRAIN.
  - Instruction/address width 16.
- No sub-module; FSM, PC and hold buffer sit inline (~150–250 lines).

## Test plan
- Reset, 1-cycle-ack memory holding 16'h1234,16'h5678 at 0,1 → `imem_addr_if` 0,1,2…; outputs (16'h1234, 1), then (16'h5678, 2); `valid_if`=1 each cycle.
- Ack delayed 3 cycles at addr 5 → `imem_addr_if` held 5 with req=1 for 3 cycles; outputs NOP, valid 0 until ack+1.
- `stall_id` high 2 cycles coinciding with ack of addr 3 → outputs frozen; no request during HOLD; after release outputs = addr-3 instruction, next PC 4; fetch of 4 follows.
- `redirect_ex` to 16'h0040 while ack pending for addr 7 → req held at 7 until ack; data discarded; next request addr 16'h0040; outputs NOP until its ack.
- Redirect with `stall_id`=1 in HOLD → outputs NOP, valid 0 next cycle; buffer dropped; request at target.
- `req_addr`=16'hFFFF acked → `next_program_counter_if`=16'h0000; next request addr 0. Also: assert reset mid-DRAIN → outputs zeroed asynchronously; request at `RESET_PC` after release.
